// File: rtl/srl_fifo_flags.sv
// Shift-register FIFO with optional first-word-fall-through read, registered
// almost-full / almost-empty flags, sticky overflow / underflow errors and a
// synchronous flush. Producer and consumer share the single clock.
module srl_fifo_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             write_en,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_en,
    output logic [WIDTH-1:0] read_data,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             almost_full_r;
    logic             almost_empty_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             rd_ok_s;
    logic             wr_ok_s;
    logic             pop_s;
    logic             push_s;
    logic [WIDTH-1:0] oldest_s;

    // Accept decisions use the flags registered at the start of the cycle;
    // a flush suppresses both the pop and the push of that cycle.
    always_comb begin
        rd_ok_s = read_en & ~empty_r;
        wr_ok_s = write_en & (~full_r | rd_ok_s);
        pop_s   = rd_ok_s & ~flush;
        push_s  = wr_ok_s & ~flush;
    end

    // Oldest word lives at slot count-1; selected with a flat mux over count.
    always_comb begin
        oldest_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            oldest_s = (count_r == CW'(i + 1)) ? mem_r[i] : oldest_s;
        end
    end

    // Next occupancy; the accept rules keep it inside 0..DEPTH.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_next_s = count_r + CW'(1);
                2'b01:   count_next_s = count_r - CW'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Storage shift chain: a push moves every word one slot deeper (not reset).
    always_ff @(posedge clk) begin
        if (push_s) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem_r[i] <= mem_r[i-1];
            end
            mem_r[0] <= write_data;
        end
    end

    // Occupancy counter and level flags, all derived from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r        <= {CW{1'b0}};
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            count_r        <= count_next_s;
            full_r         <= (count_next_s == CW'(DEPTH));
            empty_r        <= (count_next_s == {CW{1'b0}});
            almost_full_r  <= (count_next_s >= CW'(AF_LEVEL));
            almost_empty_r <= (count_next_s <= CW'(AE_LEVEL));
        end
    end

    // Sticky error flags, cleared only by flush or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (write_en & full_r & ~rd_ok_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
            if (read_en & empty_r) begin
                underflow_r <= 1'b1;
            end else begin
                underflow_r <= underflow_r;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Fall-through: the head word is presented directly; read_en pops it.
            always_comb begin
                read_data = oldest_s;
            end
        end else begin : g_std
            logic [WIDTH-1:0] read_data_r;

            // Standard read: capture the head word on an accepted pop, hold otherwise.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    read_data_r <= {WIDTH{1'b0}};
                end else if (pop_s) begin
                    read_data_r <= oldest_s;
                end else begin
                    read_data_r <= read_data_r;
                end
            end

            // Drive the port from the capture register.
            always_comb begin
                read_data = read_data_r;
            end
        end
    endgenerate

    // Port drivers for the registered status.
    always_comb begin
        count        = count_r;
        full         = full_r;
        empty        = empty_r;
        almost_full  = almost_full_r;
        almost_empty = almost_empty_r;
        overflow     = overflow_r;
        underflow    = underflow_r;
    end

endmodule
